issue_scoreboard: RTL
=====================

ISSUE_SCOREBOARD -- requirements
Module: issue_scoreboard

Interface
REQ-001 The block SHALL have parameter LANES, default 2, meaning issue lanes per bundle (legal 1..4; lane 0 is oldest in program order).
REQ-002 The block SHALL have parameter NREG, default 32, meaning architectural registers tracked (register index width RW = clog2(NREG)).
REQ-003 The block SHALL have parameter LAT_MAX, default 4, meaning the largest result latency in cycles (counter width LW = clog2(LAT_MAX+1)).
REQ-004 The block SHALL have: clk  in  1  sole clock, all state on rising edge.
REQ-005 The block SHALL have: reset  in  1  synchronous, active-high reset.
REQ-006 The block SHALL have: flush  in  1  discard all pending writes and the current bundle.
REQ-007 The block SHALL have: iss_valid  in  LANES  lane holds an instruction.
REQ-008 The block SHALL have: iss_rs, iss_rt  in  LANES*RW each  source register indices, lane i at bits [i*RW +: RW].
REQ-009 The block SHALL have: iss_rs_use, iss_rt_use  in  LANES each  source actually read.
REQ-010 The block SHALL have: iss_wr_en  in  LANES  lane writes a register.
REQ-011 The block SHALL have: iss_wr_reg  in  LANES*RW  destination index.
REQ-012 The block SHALL have: iss_lat  in  LANES*LW  cycles until the result can be forwarded.
REQ-013 The block SHALL have: iss_grant  out  LANES  lane issues this cycle.
REQ-014 The block SHALL have: stall  out  1  some valid lane was not granted.
REQ-015 The block SHALL have: busy  out  NREG  per-register pending-write flag.
REQ-016 The block SHALL have: stall_cnt  out  32  saturating count of stall cycles.

Function
REQ-017 The block SHALL keep one LW-bit countdown per register; busy[r] SHALL be 1 exactly when the counter is nonzero.
REQ-018 Register 0 SHALL never be busy and never be a hazard source.
REQ-019 Lane i SHALL be hazard-free when each used source index (nonzero) has busy=0, and does not equal the iss_wr_reg of any lane j<i with iss_valid[j]=1 and iss_wr_en[j]=1 (intra-bundle RAW).
REQ-020 Grants SHALL be in order: iss_grant[i] = iss_valid[i] & hazard-free(i) & iss_grant[i-1] (lane 0 needs no predecessor), combinational, same cycle.
REQ-021 Grants SHALL be forced to 0 while reset or flush is high.
REQ-022 stall SHALL be 1 when any lane has iss_valid=1 and iss_grant=0, and SHALL be 0 during reset and flush.
REQ-023 Each cycle, every nonzero counter SHALL decrement by 1.
REQ-024 On a granted lane with iss_wr_en=1 and a nonzero destination, that counter SHALL load min(iss_lat, LAT_MAX) instead of decrementing.
REQ-025 When several granted lanes target the same register, the highest-numbered lane's latency SHALL win (WAW allowed).
REQ-026 iss_lat=0 SHALL leave the register not busy from the next cycle; latency L>=1 SHALL keep it busy for exactly L cycles after the issue edge.
REQ-027 flush SHALL zero all counters on the next edge, and SHALL take priority over a simultaneous issue.
REQ-028 stall_cnt SHALL increment on each cycle where stall=1, and SHALL hold at 0xFFFFFFFF.

Reset
REQ-029 Reset SHALL clear all counters, so busy=0.
REQ-030 Reset SHALL clear stall_cnt to 0.
REQ-031 While reset is high: iss_grant=0 and stall=0.
REQ-032 Reset asserted mid-countdown SHALL discard all pending latencies in one cycle.

Structure
REQ-033 A shared package SHALL hold LAT_MAX default, lane-count limit and the register-index width constant.
REQ-034 One sub-module, sb_lane_check, SHALL compute the hazard-free term of one lane; it SHALL be instantiated LANES times in a generate loop.
REQ-035 Counters SHALL be a single always block over NREG entries; no latches.

Verification
REQ-036 Load-use: lane0 writes r5 with lat=2, next cycle lane0 reads r5 -> grant=0 and stall=1 for 2 cycles, grant=1 on the third cycle, stall_cnt=2.
REQ-037 Intra-bundle RAW: lane0 writes r3 and lane1 reads r3 in the same bundle -> iss_grant=01; next cycle re-present lane1 alone -> granted unless r3 is busy.
REQ-038 WAW: lane0 writes r7 with lat=3 and lane1 writes r7 with lat=1, both granted -> busy[7] is 1 for exactly 1 cycle.
REQ-039 Flush: r4 busy with count 3, flush together with a valid write to r9 lat=2 -> next cycle busy=0, grant=0 during flush.
REQ-040 r0 and clamp: write r0 lat=4 -> busy[0] stays 0; write r2 with iss_lat above LAT_MAX -> busy[2] lasts LAT_MAX cycles.
REQ-041 Saturation and reset: preload near max via forced stalls, confirm stall_cnt holds at 0xFFFFFFFF; reset mid-countdown -> busy=0 and stall_cnt=0 next cycle.

Source files
------------

// File: rtl/issue_scoreboard_pkg.sv
// Shared constants for the issue scoreboard: default sizes, lane limit and
// the register-index width helper used by the top and the lane checker.
package issue_scoreboard_pkg;

    localparam int LAT_MAX_DEFAULT = 4;
    localparam int LANES_MAX       = 4;
    localparam int NREG_DEFAULT    = 32;

    function automatic int idx_width(input int nreg);
        return (nreg > 1) ? $clog2(nreg) : 1;
    endfunction

    localparam int RW_DEFAULT = idx_width(NREG_DEFAULT);

endpackage

// File: rtl/issue_scoreboard_lane.sv
// Hazard check for one issue lane: busy sources and read-after-write on an
// older lane of the same bundle both block the lane.
module sb_lane_check
    import issue_scoreboard_pkg::*;
#(
    parameter int LANES = 2,
    parameter int NREG  = NREG_DEFAULT,
    parameter int LANE  = 0,
    localparam int RW   = idx_width(NREG)
)(
    input  logic [RW-1:0]       rs_i,
    input  logic [RW-1:0]       rt_i,
    input  logic                rs_use_i,
    input  logic                rt_use_i,
    input  logic [NREG-1:0]     busy_i,
    input  logic [LANES-1:0]    valid_i,
    input  logic [LANES-1:0]    wr_en_i,
    input  logic [LANES*RW-1:0] wr_reg_i,
    output logic                hazard_free_o
);

    logic rs_live;
    logic rt_live;
    logic hazard;

    // Register 0 is never a hazard source, so only nonzero used sources count.
    always_comb begin
        rs_live = rs_use_i && (rs_i != '0);
        rt_live = rt_use_i && (rt_i != '0);
        hazard  = (rs_live && busy_i[rs_i]) || (rt_live && busy_i[rt_i]);
        for (int j = 0; j < LANES_MAX; j++) begin
            if (j < LANE && j < LANES && valid_i[j] && wr_en_i[j]) begin
                if (rs_live && (rs_i == wr_reg_i[j*RW +: RW])) begin
                    hazard = 1'b1;
                end
                if (rt_live && (rt_i == wr_reg_i[j*RW +: RW])) begin
                    hazard = 1'b1;
                end
            end
        end
        hazard_free_o = !hazard;
    end

endmodule

// File: rtl/issue_scoreboard.sv
// In-order issue scoreboard: per-register latency countdowns, in-order lane
// grants with intra-bundle RAW detection, and a saturating stall counter.
module issue_scoreboard
    import issue_scoreboard_pkg::*;
#(
    parameter int LANES   = 2,
    parameter int NREG    = NREG_DEFAULT,
    parameter int LAT_MAX = LAT_MAX_DEFAULT,
    localparam int RW     = idx_width(NREG),
    localparam int LW     = $clog2(LAT_MAX + 1)
)(
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic [LANES-1:0]    iss_valid,
    input  logic [LANES*RW-1:0] iss_rs,
    input  logic [LANES*RW-1:0] iss_rt,
    input  logic [LANES-1:0]    iss_rs_use,
    input  logic [LANES-1:0]    iss_rt_use,
    input  logic [LANES-1:0]    iss_wr_en,
    input  logic [LANES*RW-1:0] iss_wr_reg,
    input  logic [LANES*LW-1:0] iss_lat,
    output logic [LANES-1:0]    iss_grant,
    output logic                stall,
    output logic [NREG-1:0]     busy,
    output logic [31:0]         stall_cnt
);

    logic [LW-1:0]    cnt_q [NREG];
    logic [LW-1:0]    cnt_d [NREG];
    logic [31:0]      stall_cnt_q;
    logic [31:0]      stall_cnt_d;
    logic [LANES-1:0] hazard_free;
    logic [LW-1:0]    lat_cl [LANES];
    logic             chain;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        sb_lane_check #(
            .LANES (LANES),
            .NREG  (NREG),
            .LANE  (g)
        ) u_chk (
            .rs_i          (iss_rs[g*RW +: RW]),
            .rt_i          (iss_rt[g*RW +: RW]),
            .rs_use_i      (iss_rs_use[g]),
            .rt_use_i      (iss_rt_use[g]),
            .busy_i        (busy),
            .valid_i       (iss_valid),
            .wr_en_i       (iss_wr_en),
            .wr_reg_i      (iss_wr_reg),
            .hazard_free_o (hazard_free[g])
        );
    end

    always_comb begin
        busy = '0;
        for (int r = 1; r < NREG; r++) begin
            busy[r] = (cnt_q[r] != '0);
        end
    end

    // A lane issues only if every older lane issued too.
    always_comb begin
        iss_grant = '0;
        chain     = 1'b1;
        for (int i = 0; i < LANES; i++) begin
            chain        = chain && iss_valid[i] && hazard_free[i];
            iss_grant[i] = chain;
        end
        if (reset || flush) begin
            iss_grant = '0;
        end
        stall = !(reset || flush) && ((iss_valid & ~iss_grant) != '0);
    end

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            if (int'(iss_lat[i*LW +: LW]) > LAT_MAX) begin
                lat_cl[i] = LW'(LAT_MAX);
            end else begin
                lat_cl[i] = iss_lat[i*LW +: LW];
            end
        end
    end

    // Later lanes overwrite earlier ones so the youngest writer's latency wins.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - LW'(1) : '0;
            for (int i = 0; i < LANES; i++) begin
                if (iss_grant[i] && iss_wr_en[i] && (iss_wr_reg[i*RW +: RW] == RW'(r))) begin
                    cnt_d[r] = lat_cl[i];
                end
            end
            if (flush || (r == 0)) begin
                cnt_d[r] = '0;
            end
        end
        stall_cnt_d = (stall && (stall_cnt_q != '1)) ? stall_cnt_q + 32'd1 : stall_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
            stall_cnt_q <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule
